alarm_module: RTL and testbench

- Alarm stage downstream of clockWork. Consumes its 17-bit time_out bus, {hour[4:0], min[5:0], sec[5:0]}.
- Holds one programmable alarm time (hh:mm) and raises a ringing output when the running time reaches it.
- Supports snooze, stop and automatic ring timeout.
- Runs on the fast system clock; detects clock seconds by watching for changes on the time bus.

---
 rtl/alarm_module.sv | 109 ++++++++++
 tb/tb_alarm_module.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/alarm_module.sv
// Alarm stage behind clockWork: one programmable hh:mm alarm with snooze, stop and ring timeout.
// Optional beep output is enabled with the ALARM_BEEP_EN macro.
module alarm_module #(
   parameter int SNOOZE_MIN       = 5,
   parameter int RING_TIMEOUT_MIN = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [16:0] time_in,
   input  logic [10:0] alarm_in,
   input  logic        alarm_ow,
   input  logic        arm,
   input  logic        snooze,
   input  logic        stop,
   output logic [10:0] alarm_out,
   output logic        ringing,
`ifdef ALARM_BEEP_EN
   output logic        beep,
`endif
   output logic        snoozed
);

   typedef enum logic [1:0] {IDLE, ARMED, RINGING, SNOOZED} state_t;

   state_t      state, state_nxt;
   logic [16:0] time_prev;
   logic [10:0] snz_target, snz_calc;
   logic [5:0]  cnt;
   logic [6:0]  snz_sum;
   logic [4:0]  snz_hr;
   logic [5:0]  snz_min;
   logic        new_sec, min_tick, wr_ok, hit_alarm, hit_snz, timeout;

   assign new_sec   = (time_in != time_prev);
   assign min_tick  = new_sec && (time_in[5:0] == 6'd0);
   assign wr_ok     = alarm_ow && (alarm_in[10:6] <= 5'd23) && (alarm_in[5:0] <= 6'd59);
   assign hit_alarm = min_tick && (time_in[16:6] == alarm_out);
   assign hit_snz   = min_tick && (time_in[16:6] == snz_target);
   // The entry tick is not counted, so the tick that would make the count reach the limit ends ringing.
   assign timeout   = min_tick && (cnt >= 6'(RING_TIMEOUT_MIN - 1));

   // Snooze target: minute wraps at 60 carrying into the hour, hour wraps at 24.
   always_comb begin
      snz_sum = {1'b0, time_in[11:6]} + 7'(SNOOZE_MIN);
      snz_hr  = time_in[16:12];
      snz_min = snz_sum[5:0];
      if (snz_sum >= 7'd60) begin
         snz_min = 6'(snz_sum - 7'd60);
         snz_hr  = (time_in[16:12] >= 5'd23) ? 5'd0 : time_in[16:12] + 5'd1;
      end
      snz_calc = {snz_hr, snz_min};
   end

   always_comb begin
      state_nxt = state;
      if (!arm)
         state_nxt = IDLE;
      else if (wr_ok)
         state_nxt = ARMED;
      else begin
         case (state)
            IDLE:    state_nxt = ARMED;
            ARMED:   if (hit_alarm) state_nxt = RINGING;
            RINGING: begin
               if (stop)         state_nxt = ARMED;
               else if (snooze)  state_nxt = SNOOZED;
               else if (timeout) state_nxt = ARMED;
            end
            SNOOZED: begin
               if (stop)         state_nxt = ARMED;
               else if (hit_snz) state_nxt = RINGING;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         ringing    <= 1'b0;
         snoozed    <= 1'b0;
         alarm_out  <= 11'd0;
         time_prev  <= 17'd0;
         snz_target <= 11'd0;
         cnt        <= 6'd0;
`ifdef ALARM_BEEP_EN
         beep       <= 1'b0;
`endif
      end else begin
         state     <= state_nxt;
         ringing   <= (state_nxt == RINGING);
         snoozed   <= (state_nxt == SNOOZED);
         time_prev <= time_in;
`ifdef ALARM_BEEP_EN
         beep      <= (state_nxt == RINGING) && time_in[0];
`endif
         if (wr_ok)
            alarm_out <= alarm_in;
         if (state == RINGING && state_nxt == SNOOZED)
            snz_target <= snz_calc;
         if (state_nxt == RINGING && state != RINGING)
            cnt <= 6'd0;
         else if (state == RINGING && min_tick && cnt != 6'h3f)
            cnt <= cnt + 6'd1;
      end
   end

endmodule

// File: tb/tb_alarm_module.sv
// Directed bench for alarm_module; expectations queued at drive time, checked after each edge.
module tb_alarm_module;

   logic        clk = 1'b0;
   logic        rst;
   logic [16:0] time_in;
   logic [10:0] alarm_in;
   logic        alarm_ow, arm, snooze, stop;
   logic [10:0] alarm_out;
   logic        ringing, snoozed;
`ifdef ALARM_BEEP_EN
   logic        beep;
`endif

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string       tag;
      logic        r;
      logic        s;
      logic [10:0] a;
   } exp_t;

   exp_t sb[$];

   alarm_module dut (
      .clk(clk), .rst(rst), .time_in(time_in), .alarm_in(alarm_in),
      .alarm_ow(alarm_ow), .arm(arm), .snooze(snooze), .stop(stop),
      .alarm_out(alarm_out), .ringing(ringing),
`ifdef ALARM_BEEP_EN
      .beep(beep),
`endif
      .snoozed(snoozed)
   );

   always #5 clk = ~clk;

   function automatic logic [16:0] t(input int h, input int m, input int s);
      return {5'(h), 6'(m), 6'(s)};
   endfunction

   function automatic logic [10:0] hm(input int h, input int m);
      return {5'(h), 6'(m)};
   endfunction

   task automatic push(input string tag, input logic r, input logic s, input logic [10:0] a);
      exp_t e;
      e.tag = tag; e.r = r; e.s = s; e.a = a;
      sb.push_back(e);
   endtask

   task automatic compare();
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         failures++;
         $error("FAIL scoreboard_empty got=%0d required=1", sb.size());
      end else begin
         e = sb.pop_front();
         assert ({ringing, snoozed, alarm_out} === {e.r, e.s, e.a}) else begin
            failures++;
            $error("FAIL %s got r=%b s=%b a=%h required r=%b s=%b a=%h",
                   e.tag, ringing, snoozed, alarm_out, e.r, e.s, e.a);
         end
      end
   endtask

   // One clock edge with an expectation on the state seen just after it.
   task automatic tick(input string tag, input logic r, input logic s, input logic [10:0] a);
      push(tag, r, s, a);
      @(posedge clk); #1;
      compare();
   endtask

   initial begin
      rst = 1'b1; time_in = '0; alarm_in = '0;
      alarm_ow = 0; arm = 0; snooze = 0; stop = 0;
      #12;
      push("reset", 0, 0, 11'd0); compare();
      @(posedge clk); #1;
      rst = 1'b0;

      // Stray snooze/stop while armed are ignored
      arm = 1; snooze = 1; stop = 1;
      tick("ignore_pulses", 0, 0, 11'd0);
      snooze = 0; stop = 0;

      // Basic ring at 07:30
      alarm_ow = 1; alarm_in = hm(7, 30); time_in = t(7, 29, 58);
      tick("write_0730", 0, 0, 11'b00111_011110);
      alarm_ow = 0;
      time_in = t(7, 29, 59); tick("pre_ring", 0, 0, hm(7, 30));
      time_in = t(7, 30, 0);  tick("ring_rise", 1, 0, hm(7, 30));
      time_in = t(7, 30, 1);  tick("ring_hold", 1, 0, hm(7, 30));

      // Auto timeout after 10 minute ticks
      for (int m = 31; m <= 39; m++) begin
         time_in = t(7, m, 0);
         tick("timeout_ring", 1, 0, hm(7, 30));
      end
      time_in = t(7, 39, 59); tick("timeout_0739_59", 1, 0, hm(7, 30));
      time_in = t(7, 40, 0);  tick("timeout_0740", 0, 0, hm(7, 30));
      time_in = t(7, 40, 1);  tick("timeout_armed", 0, 0, hm(7, 30));

      // Stop inside the alarm minute, then next-day retrigger
      time_in = t(7, 29, 59); tick("stop_pre", 0, 0, hm(7, 30));
      time_in = t(7, 30, 0);  tick("stop_ring", 1, 0, hm(7, 30));
      time_in = t(7, 30, 5); stop = 1;
      tick("stop_edge", 0, 0, hm(7, 30));
      stop = 0;
      time_in = t(7, 30, 6);  tick("stop_no_retrig", 0, 0, hm(7, 30));
      time_in = t(7, 31, 0);  tick("stop_0731", 0, 0, hm(7, 30));
      time_in = t(7, 29, 59); tick("nextday_pre", 0, 0, hm(7, 30));
      time_in = t(7, 30, 0);  tick("nextday_ring", 1, 0, hm(7, 30));
      stop = 1; tick("nextday_stop", 0, 0, hm(7, 30));
      stop = 0;

      // Snooze across midnight: 23:58 + 5 = 00:03
      alarm_ow = 1; alarm_in = hm(23, 58);
      tick("write_2358", 0, 0, hm(23, 58));
      alarm_ow = 0;
      time_in = t(23, 57, 59); tick("snz_pre", 0, 0, hm(23, 58));
      time_in = t(23, 58, 0);  tick("snz_ring", 1, 0, hm(23, 58));
      snooze = 1; tick("snz_enter", 0, 1, hm(23, 58));
      snooze = 0;
      time_in = t(0, 2, 59); tick("snz_0002_59", 0, 1, hm(23, 58));
      time_in = t(0, 3, 0);  tick("snz_0003", 1, 0, hm(23, 58));
      stop = 1; tick("snz_stop", 0, 0, hm(23, 58));
      stop = 0;

      // Invalid writes are ignored
      alarm_ow = 1; alarm_in = hm(24, 10);
      tick("inv_hour", 0, 0, hm(23, 58));
      alarm_in = hm(5, 60);
      tick("inv_min", 0, 0, hm(23, 58));
      alarm_ow = 0;

      // Disarm while ringing; no hit while disarmed
      time_in = t(23, 57, 59); tick("disarm_pre", 0, 0, hm(23, 58));
      time_in = t(23, 58, 0);  tick("disarm_ring", 1, 0, hm(23, 58));
      arm = 0; tick("disarm_drop", 0, 0, hm(23, 58));
      time_in = t(23, 57, 59); tick("disarm_pre2", 0, 0, hm(23, 58));
      time_in = t(23, 58, 0);  tick("disarm_nohit", 0, 0, hm(23, 58));
      arm = 1; tick("rearm", 0, 0, hm(23, 58));

      // Valid write while ringing returns to armed
      time_in = t(23, 57, 59); tick("wr_pre", 0, 0, hm(23, 58));
      time_in = t(23, 58, 0);  tick("wr_ring", 1, 0, hm(23, 58));
      alarm_ow = 1; alarm_in = hm(7, 30);
      tick("wr_during_ring", 0, 0, hm(7, 30));
      alarm_ow = 0;

      // Overwrite to mid-minute never fires
      time_in = t(7, 30, 30); tick("ovw_ss30", 0, 0, hm(7, 30));
      time_in = t(7, 29, 59); tick("ovw_pre", 0, 0, hm(7, 30));
      time_in = t(7, 30, 0);  tick("ovw_exact", 1, 0, hm(7, 30));

      // Asynchronous reset mid-ring
      #2 rst = 1'b1;
      #1;
      push("async_rst", 0, 0, 11'd0); compare();
      @(posedge clk); #1;
      rst = 1'b0;

      if (sb.size() != 0) begin
         failures++;
         $error("FAIL scoreboard_leftover got=%0d required=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
